mult_div_unit: RTL and testbench

- Iterative multiply/divide unit beside the ALU in the EX stage; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU on rs/rt operands, and services MTHI/MTLO writes.
- Drives busy to the hazard unit so the pipeline stalls while an operation is in flight.
- Provides HI/LO as read data for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mult_div_unit_if.sv | 31 +++
 rtl/mdu_iter_core.sv | 70 +++++++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default datapath width / iteration count.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   start/op/rs_val/rt_val : operation request
//   mthi/mtlo/wr_data      : direct HI/LO writes
//   busy/done/div_by_zero  : status back to the pipeline
//   hi/lo                  : architectural HI/LO read data
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter_core.sv
// One shift-add multiply or restoring shift-subtract divide step per cycle on
// unsigned magnitudes.
//   load    : capture a_mag (multiplier/dividend) and b_mag, clear counter
//   step    : perform one iteration
//   is_div  : select divide step instead of multiply step
//   acc_hi  : product upper half / remainder
//   acc_lo  : product lower half / quotient
//   last_c  : current step is the final iteration
module mdu_iter_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last_c
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(ITERS);

  logic [W-1:0]  operand_b;
  logic [CW-1:0] count;
  logic [W:0]    mul_sum;
  logic [W:0]    div_rsh;
  logic          div_ge;
  logic [W-1:0]  hi_nxt;
  logic [W-1:0]  lo_nxt;

  assign last_c = (count == CW'(ITERS - 1));

  // Next accumulator value for one multiply or divide iteration
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    div_rsh = {acc_hi, acc_lo[W-1]};
    div_ge  = (div_rsh >= {1'b0, operand_b});
    if (is_div) begin
      hi_nxt = div_ge ? W'(div_rsh - {1'b0, operand_b}) : div_rsh[W-1:0];
      lo_nxt = {acc_lo[W-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[W:1];
      lo_nxt = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  // Accumulator, operand and iteration counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      count     <= '0;
    end else if (load) begin
      acc_hi    <= '0;
      acc_lo    <= a_mag;
      operand_b <= b_mag;
      count     <= '0;
    end else if (step) begin
      acc_hi    <= hi_nxt;
      acc_lo    <= lo_nxt;
      count     <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request, MTHI/MTLO writes, busy/done/div_by_zero, hi/lo
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned ITERS = MDU_ITERS
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned W = WIDTH;

  mdu_state_e    state_q, state_d;
  mdu_op_e       op_in;
  logic          in_signed, in_div, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;

  logic          div_q, neg_q, rem_neg_q, div0_q;
  logic          busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          core_load, core_step, accept;

  logic [W-1:0]   acc_hi, acc_lo;
  logic           last_c;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  // Operand decode and magnitudes; -0x80000000 stays 0x80000000 = 2^31
  always_comb begin
    op_in     = mdu_op_e'(bus.op);
    in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    in_div    = (op_in == MDU_DIV)  || (op_in == MDU_DIVU);
    a_neg     = in_signed & bus.rs_val[W-1];
    b_neg     = in_signed & bus.rt_val[W-1];
    a_mag     = a_neg ? -bus.rs_val : bus.rs_val;
    b_mag     = b_neg ? -bus.rt_val : bus.rt_val;
  end

  mdu_iter_core #(.WIDTH(W), .ITERS(ITERS)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (div_q),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .last_c (last_c)
  );

  // Sign correction of the unsigned core result
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = rem_neg_q ? -acc_hi : acc_hi;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, HI/LO update and status outputs
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    core_load = 1'b0;
    core_step = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // start takes priority over a same-cycle MTHI/MTLO
          accept    = 1'b1;
          core_load = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end else begin
          if (bus.mthi) hi_d = bus.wr_data;
          if (bus.mtlo) lo_d = bus.wr_data;
        end
      end
      S_RUN: begin
        if (div0_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
        end else begin
          core_step = 1'b1;
          if (last_c) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (bus.mthi) hi_d = bus.wr_data;
        if (bus.mtlo) lo_d = bus.wr_data;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and latched operation attributes
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      if (accept) begin
        div_q     <= in_div;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div0_q    <= in_div && (bus.rt_val == '0);
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; sampling/driving happens 1ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (E0), then drop start
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start  = 1'b1;
    cyc();
    bus.start  = 1'b0;
  endtask

  // Wait (bounded) for done; lat = edges after E0 when done is seen, 0 on timeout
  task automatic wait_done(input int elapsed, output int lat, output int busy_cnt,
                           output logic dbz, output logic busy_at_done);
    lat          = 0;
    dbz          = 1'b0;
    busy_at_done = 1'b1;
    busy_cnt     = bus.busy ? 1 : 0;
    for (int i = elapsed + 1; i <= 100; i++) begin
      cyc();
      if (bus.done) begin
        lat          = i;
        dbz          = bus.div_by_zero;
        busy_at_done = bus.busy;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    tests++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      fails++; $display("FAIL reset_status: got %b want 000", {bus.busy, bus.done, bus.div_by_zero}); end
  endtask

  task automatic test_mult();
    int lat, bc; logic dbz, bad;
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if (lat != 33) begin fails++; $display("FAIL mult_latency: got %0d want 33", lat); end
    // busy seen high in the 33 cycles from after E0 up to E33
    tests++; if (bc != 33) begin fails++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL mult_busy_at_done: got %b want 0", bad); end
    tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_neg_hi: got %h want FFFFFFFF", bus.hi); end
    tests++; if (bus.lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_neg_lo: got %h want FFFFFFEB", bus.lo); end
    cyc();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL mult_done_one_cycle: got %b want 0", bus.done); end
  endtask

  task automatic test_mult_corners();
    int lat, bc; logic dbz, bad;
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin
      fails++; $display("FAIL multu_max: got %h want FFFFFFFE00000001", {bus.hi, bus.lo}); end
    cyc();
    launch(2'b00, 32'h80000000, 32'h80000000);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if ({bus.hi, bus.lo} !== 64'h40000000_00000000) begin
      fails++; $display("FAIL mult_minneg_sq: got %h want 4000000000000000", {bus.hi, bus.lo}); end
    cyc();
  endtask

  task automatic test_div();
    int lat, bc; logic dbz, bad;
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if (lat != 33) begin fails++; $display("FAIL div_latency: got %0d want 33", lat); end
    tests++; if (bus.lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_quo: got %h want FFFFFFFD", bus.lo); end
    tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_rem: got %h want FFFFFFFF", bus.hi); end
    cyc();
    launch(2'b11, 32'd100, 32'd7);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if (bus.lo !== 32'd14) begin fails++; $display("FAIL divu_quo: got %h want 0000000E", bus.lo); end
    tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL divu_rem: got %h want 00000002", bus.hi); end
    cyc();
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin
      fails++; $display("FAIL div_overflow: got %h want 0000000080000000", {bus.hi, bus.lo}); end
    tests++; if (dbz !== 1'b0) begin fails++; $display("FAIL div_overflow_flag: got %b want 0", dbz); end
    cyc();
  endtask

  task automatic test_div_by_zero();
    int lat, bc; logic dbz, bad;
    bus.wr_data = 32'h33; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    cyc();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    tests++; if ({bus.hi, bus.lo} !== 64'h00000033_00000033) begin
      fails++; $display("FAIL mt_both: got %h want 0000003300000033", {bus.hi, bus.lo}); end
    bus.wr_data = 32'h11; bus.mthi = 1'b1;
    cyc();
    bus.mthi = 1'b0; bus.wr_data = 32'h22; bus.mtlo = 1'b1;
    cyc();
    bus.mtlo = 1'b0;
    tests++; if ({bus.hi, bus.lo} !== 64'h00000011_00000022) begin
      fails++; $display("FAIL mt_preload: got %h want 0000001100000022", {bus.hi, bus.lo}); end
    launch(2'b11, 32'd5, 32'd0);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL dbz_busy: got %b want 1", bus.busy); end
    wait_done(0, lat, bc, dbz, bad);
    tests++; if (lat != 1) begin fails++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    tests++; if (dbz !== 1'b1) begin fails++; $display("FAIL dbz_flag: got %b want 1", dbz); end
    tests++; if ({bus.hi, bus.lo} !== 64'h00000011_00000022) begin
      fails++; $display("FAIL dbz_hilo_kept: got %h want 0000001100000022", {bus.hi, bus.lo}); end
    cyc();
    tests++; if ({bus.done, bus.div_by_zero} !== 2'b00) begin
      fails++; $display("FAIL dbz_pulse_width: got %b want 00", {bus.done, bus.div_by_zero}); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, pulses; logic dbz, bad;
    launch(2'b00, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    tests++; if ({bus.hi, bus.lo} !== 64'h0) begin
      fails++; $display("FAIL rst_mid_hilo: got %h want 0000000000000000", {bus.hi, bus.lo}); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.done) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", pulses); end
    launch(2'b01, 32'd6, 32'd7);
    wait_done(0, lat, bc, dbz, bad);
    tests++; if (lat != 33 || {bus.hi, bus.lo} !== 64'd42) begin
      fails++; $display("FAIL rst_mid_restart: got lat %0d val %h want lat 33 val 000000000000002A", lat, {bus.hi, bus.lo}); end
    cyc();
  endtask

  task automatic test_ignore_while_busy();
    int lat, bc; logic dbz, bad;
    launch(2'b11, 32'd1000, 32'd10);
    bus.op = 2'b00; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    bus.start = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'h55;
    cyc();
    bus.start = 1'b0; bus.mtlo = 1'b0;
    tests++; if (bus.lo === 32'h55) begin fails++; $display("FAIL run_mtlo_ignored: got %h want not 00000055", bus.lo); end
    wait_done(1, lat, bc, dbz, bad);
    tests++; if (lat != 33) begin fails++; $display("FAIL run_start_ignored_lat: got %0d want 33", lat); end
    tests++; if ({bus.hi, bus.lo} !== 64'd100) begin
      fails++; $display("FAIL run_start_ignored_val: got %h want 0000000000000064", {bus.hi, bus.lo}); end
    cyc();
  endtask

  task automatic test_start_with_mtlo();
    int lat, bc; logic dbz, bad;
    bus.mtlo = 1'b1; bus.wr_data = 32'h55;
    launch(2'b11, 32'd100, 32'd7);
    bus.mtlo = 1'b0;
    wait_done(0, lat, bc, dbz, bad);
    tests++; if (bus.lo !== 32'd14) begin fails++; $display("FAIL start_wins_lo: got %h want 0000000E", bus.lo); end
    tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL start_wins_hi: got %h want 00000002", bus.hi); end
    cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_mult();
    test_mult_corners();
    test_div();
    test_div_by_zero();
    test_reset_mid_op();
    test_ignore_while_busy();
    test_start_with_mtlo();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
